// File: rtl/cam_stream_gen_if.sv
// Camera-side bus of the synthetic OV7670 source: pixel clock, line/frame sync, pixel byte.
// The generator drives it through master; the capture block samples it through slave.
interface cam_stream_gen_if;
    logic       CAM_pclk;
    logic       CAM_href;
    logic       CAM_vsync;
    logic [7:0] CAM_px_data;

    modport master (
        output CAM_pclk,
        output CAM_href,
        output CAM_vsync,
        output CAM_px_data
    );

    modport slave (
        input CAM_pclk,
        input CAM_href,
        input CAM_vsync,
        input CAM_px_data
    );
endinterface

// File: rtl/cam_stream_gen.sv
// Synthetic OV7670-style QQVGA RGB444 colour-bar source, two bytes per pixel, pclk = clk/2.
// Optional macro CAM_GEN_SCROLL_EN: bars scroll one pixel left per frame.
module cam_stream_gen #(
    parameter int unsigned CAM_SCREEN_X = 160,
    parameter int unsigned CAM_SCREEN_Y = 120,
    parameter int unsigned VS_LINES     = 3,
    parameter int unsigned VBP_LINES    = 17,
    parameter int unsigned VFP_LINES    = 10,
    parameter int unsigned HBLANK       = 144
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    cam_stream_gen_if.master cam,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned LINE_T  = 2 * CAM_SCREEN_X + HBLANK;
    localparam int unsigned TOTAL_L = VS_LINES + VBP_LINES + CAM_SCREEN_Y + VFP_LINES;
    localparam int unsigned HW      = $clog2(LINE_T);
    localparam int unsigned VW      = $clog2(TOTAL_L);
    localparam int unsigned XW      = $clog2(CAM_SCREEN_X);

    localparam logic [HW-1:0] H_LAST   = HW'(LINE_T - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(2 * CAM_SCREEN_X);
    localparam logic [VW-1:0] V_VBACK  = VW'(VS_LINES);
    localparam logic [VW-1:0] V_ACTIVE = VW'(VS_LINES + VBP_LINES);
    localparam logic [VW-1:0] V_VFRONT = VW'(VS_LINES + VBP_LINES + CAM_SCREEN_Y);
    localparam logic [VW-1:0] V_LAST   = VW'(TOTAL_L - 1);
    localparam logic [XW-1:0] BAR_DIV  = XW'(CAM_SCREEN_X / 8);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    state_t        state, state_nx;
    logic [HW-1:0] hcnt, hcnt_nx;
    logic [VW-1:0] vcnt, vcnt_nx;

    logic          pclk_q;
    logic          upd;
    logic          h_last;
    logic          v_last;
    logic          frame_end;

    logic          href_nx;
    logic          vsync_nx;
    logic [7:0]    data_nx;
    logic [XW-1:0] x_nx;
    logic [XW-1:0] xs_nx;
    logic [2:0]    bar_nx;
    logic [11:0]   rgb_nx;

    logic          href_q;
    logic          vsync_q;
    logic [7:0]    data_q;
    logic          busy_q;
    logic          done_q;

    // An update edge is the clk edge on which pclk falls.
    assign upd       = pclk_q;
    assign h_last    = (hcnt == H_LAST);
    assign v_last    = (vcnt == V_LAST);
    assign frame_end = (state == VFRONT) && h_last && v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk_q <= 1'b0;
        end else begin
            pclk_q <= ~pclk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
            vcnt  <= vcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        vcnt_nx  = vcnt;
        if (upd) begin
            if (state == IDLE) begin
                if (en) begin
                    state_nx = VSYNC;
                end
            end else if (!h_last) begin
                hcnt_nx = hcnt + 1'b1;
            end else begin
                hcnt_nx = '0;
                if (v_last) begin
                    vcnt_nx  = '0;
                    state_nx = en ? VSYNC : IDLE;
                end else begin
                    vcnt_nx = vcnt + 1'b1;
                    if (vcnt_nx == V_VFRONT) begin
                        state_nx = VFRONT;
                    end else if (vcnt_nx == V_ACTIVE) begin
                        state_nx = ACTIVE;
                    end else if (vcnt_nx == V_VBACK) begin
                        state_nx = VBACK;
                    end
                end
            end
        end
    end

`ifdef CAM_GEN_SCROLL_EN
    localparam logic [XW:0]   X_LIM  = (XW + 1)'(CAM_SCREEN_X);
    localparam logic [XW-1:0] X_LAST = XW'(CAM_SCREEN_X - 1);

    logic [XW-1:0] frame_cnt;
    logic [XW:0]   xsum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (!upd && frame_end) begin
            frame_cnt <= (frame_cnt == X_LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    always_comb begin
        xsum  = {1'b0, x_nx} + {1'b0, frame_cnt};
        xs_nx = (xsum >= X_LIM) ? XW'(xsum - X_LIM) : XW'(xsum);
    end
`else
    always_comb begin
        xs_nx = x_nx;
    end
`endif

    // Outputs are decoded from the next counters and registered on the update edge.
    always_comb begin
        href_nx  = (state_nx == ACTIVE) && (hcnt_nx < H_ACT);
        vsync_nx = (state_nx == VSYNC);
        x_nx     = XW'(hcnt_nx >> 1);
        bar_nx   = 3'(xs_nx / BAR_DIV);
        rgb_nx   = 12'h000;
        case (bar_nx)
            3'd0: rgb_nx = 12'hFFF;
            3'd1: rgb_nx = 12'hFF0;
            3'd2: rgb_nx = 12'h0FF;
            3'd3: rgb_nx = 12'h0F0;
            3'd4: rgb_nx = 12'hF0F;
            3'd5: rgb_nx = 12'hF00;
            3'd6: rgb_nx = 12'h00F;
            3'd7: rgb_nx = 12'h000;
        endcase
        data_nx = '0;
        if (href_nx) begin
            data_nx = hcnt_nx[0] ? rgb_nx[7:0] : {4'h0, rgb_nx[11:8]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else if (upd) begin
            href_q  <= href_nx;
            vsync_q <= vsync_nx;
            data_q  <= data_nx;
            busy_q  <= (state_nx != IDLE);
        end
    end

    // Raised on the edge before the final update edge, so the next vsync follows one clk later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= !upd && frame_end;
        end
    end

    assign cam.CAM_pclk    = pclk_q;
    assign cam.CAM_href    = href_q;
    assign cam.CAM_vsync   = vsync_q;
    assign cam.CAM_px_data = data_q;
    assign frame_done      = done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen on a shrunken frame: a flat frame-time reference model
// (line = t / LINE_T, column = t % LINE_T) plus directed timing and pixel checks.
`timescale 1ns/1ps
module tb_cam_stream_gen;

    localparam int X       = 32;
    localparam int Y       = 4;
    localparam int VS      = 2;
    localparam int VBP     = 2;
    localparam int VFP     = 2;
    localparam int HB      = 8;
    localparam int LINE_T  = 2 * X + HB;
    localparam int LINES   = VS + VBP + Y + VFP;
    localparam int FRAME_T = LINE_T * LINES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic frame_done;
    logic busy;

    cam_stream_gen_if cam ();

    cam_stream_gen #(
        .CAM_SCREEN_X (X),
        .CAM_SCREEN_Y (Y),
        .VS_LINES     (VS),
        .VBP_LINES    (VBP),
        .VFP_LINES    (VFP),
        .HBLANK       (HB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cam        (cam),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state: frame time in pclk periods.
    bit m_pclk;
    bit m_run;
    int m_t;
    int m_frames = 0;
    int m_fcnt;

    logic [11:0] bar_rgb [8];
    logic [7:0]  ln0 [2*X];
    logic [7:0]  ln1 [2*X];

    // Observation counters on DUT outputs.
    bit prev_href, prev_vs;
    int hi_edges, href_pulses, vs_cycles;
    int fd_cyc[$];
    int vs_rise[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int col);
        int xs;
        logic [11:0] rgb;
        xs = col / 2;
`ifdef CAM_GEN_SCROLL_EN
        xs = (xs + m_fcnt) % X;
`endif
        rgb = bar_rgb[xs / (X / 8)];
        return (col % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
    endfunction

    task automatic model_reset();
        m_pclk = 1'b0;
        m_run  = 1'b0;
        m_t    = 0;
        m_fcnt = 0;
    endtask

    task automatic advance();
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else if (m_t == FRAME_T - 1) begin
            m_frames++;
            m_fcnt = (m_fcnt + 1) % X;
            m_t    = 0;
            if (!en) m_run = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    task automatic step();
        bit was_hi;
        int line, col;
        logic e_vs, e_href, e_fd;
        logic [7:0] e_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            was_hi = m_pclk;
            m_pclk = !m_pclk;
            if (was_hi) advance();
        end
        line   = m_t / LINE_T;
        col    = m_t % LINE_T;
        e_vs   = m_run && (line < VS);
        e_href = m_run && (line >= VS + VBP) && (line < VS + VBP + Y) && (col < 2 * X);
        e_data = e_href ? exp_byte(col) : 8'h00;
        e_fd   = m_run && (m_t == FRAME_T - 1) && m_pclk;
        check("pclk",       cam.CAM_pclk,    m_pclk);
        check("vsync",      cam.CAM_vsync,   e_vs);
        check("href",       cam.CAM_href,    e_href);
        check("px_data",    cam.CAM_px_data, e_data);
        check("busy",       busy,            m_run);
        check("frame_done", frame_done,      e_fd);

        if (m_run && m_pclk && line == VS + VBP && col < 2 * X && m_frames < 2) begin
            if (m_frames == 0) ln0[col] = cam.CAM_px_data;
            else               ln1[col] = cam.CAM_px_data;
        end

        if (rst) begin
            prev_href   = 1'b0;
            prev_vs     = 1'b0;
            hi_edges    = 0;
            href_pulses = 0;
            vs_cycles   = 0;
        end else begin
            if (cam.CAM_href && cam.CAM_pclk) hi_edges++;
            if (prev_href && !cam.CAM_href) begin
                check("href_edges_per_line", hi_edges, 2 * X);
                hi_edges = 0;
            end
            if (!prev_href && cam.CAM_href) href_pulses++;
            if (cam.CAM_vsync) vs_cycles++;
            if (prev_vs && !cam.CAM_vsync) begin
                check("vsync_width", vs_cycles, VS * LINE_T * 2);
                vs_cycles = 0;
            end
            if (!prev_vs && cam.CAM_vsync) begin
                vs_rise.push_back(cyc);
                href_pulses = 0;
            end
            if (frame_done) begin
                fd_cyc.push_back(cyc);
                check("href_pulses_per_frame", href_pulses, Y);
            end
            prev_href = cam.CAM_href;
            prev_vs   = cam.CAM_vsync;
        end
    endtask

    initial begin
        int bound, idle, target, period, gap;
        bar_rgb = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        for (int i = 0; i < 2 * X; i++) begin
            ln0[i] = 8'hA5;
            ln1[i] = 8'hA5;
        end
        model_reset();

        // Reset state
        rst = 1'b1;
        en  = 1'b0;
        repeat (4) step();
        rst = 1'b0;

        idle = 4 + $urandom_range(0, 12);
        repeat (idle) step();
        check("vsync_idle", cam.CAM_vsync, 1'b0);

        // Start latency and two back-to-back frames
        en = 1'b1;
        step();
        step();
        check("start_latency_vsync", cam.CAM_vsync, 1'b1);

        bound = 0;
        while (fd_cyc.size() < 2 && bound < 3 * FRAME_T * 2) begin
            step();
            bound++;
        end
        check("two_frames_seen", fd_cyc.size(), 2);
        period = (fd_cyc.size() >= 2) ? fd_cyc[1] - fd_cyc[0] : -1;
        check("frame_period_clk", period, FRAME_T * 2);
        gap = (fd_cyc.size() >= 1 && vs_rise.size() >= 2) ? vs_rise[1] - fd_cyc[0] : -1;
        check("vsync_after_frame_done", gap, 1);

        // First active line pixel values
        check("f0_px0_b0",    ln0[0],       8'h0F);
        check("f0_px0_b1",    ln0[1],       8'hFF);
        check("f0_yellow_b0", ln0[2*(X/8)],   8'h0F);
        check("f0_yellow_b1", ln0[2*(X/8)+1], 8'hF0);
        check("f0_last_b0",   ln0[2*X-2],   8'h00);
        check("f0_last_b1",   ln0[2*X-1],   8'h00);
        check("f0_pxm1_b0",   ln0[2*(X/8)-2], 8'h0F);
        check("f0_pxm1_b1",   ln0[2*(X/8)-1], 8'hFF);
`ifdef CAM_GEN_SCROLL_EN
        check("f1_scroll_b0", ln1[2*(X/8)-2], 8'h0F);
        check("f1_scroll_b1", ln1[2*(X/8)-1], 8'hF0);
`else
        check("f1_static_b0", ln1[2*(X/8)-2], 8'h0F);
        check("f1_static_b1", ln1[2*(X/8)-1], 8'hFF);
`endif

        // Drop en mid-frame in the third frame
        target = (VS + VBP + $urandom_range(0, Y - 1)) * LINE_T + $urandom_range(0, LINE_T - 1);
        bound = 0;
        while (!(m_run && m_t == target) && bound < FRAME_T * 2 + 10) begin
            step();
            bound++;
        end
        check("reach_stop_point", (m_run && m_t == target), 1'b1);
        en = 1'b0;
        bound = 0;
        while (fd_cyc.size() < 3 && bound < FRAME_T * 2 + 10) begin
            step();
            bound++;
        end
        check("stop_frame_done", fd_cyc.size(), 3);
        step();
        step();
        check("busy_after_stop", busy, 1'b0);
        repeat (FRAME_T * 2 + 100) step();
        check("no_restart_vsync", vs_rise.size(), 3);

        // Asynchronous reset mid-line
        en = 1'b1;
        target = (VS + VBP + 1) * LINE_T + 10;
        bound = 0;
        while (!(m_run && m_t == target) && bound < FRAME_T * 2 + 10) begin
            step();
            bound++;
        end
        check("reach_midline", (m_run && m_t == target), 1'b1);
        check("href_before_reset", cam.CAM_href, 1'b1);
        rst = 1'b1;
        #2;
        check("rst_pclk",  cam.CAM_pclk,    1'b0);
        check("rst_href",  cam.CAM_href,    1'b0);
        check("rst_vsync", cam.CAM_vsync,   1'b0);
        check("rst_data",  cam.CAM_px_data, 8'h00);
        check("rst_busy",  busy,            1'b0);
        check("rst_done",  frame_done,      1'b0);
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        en  = 1'b0;
        repeat (30) step();
        check("vsync_low_after_reset", cam.CAM_vsync, 1'b0);
        en = 1'b1;
        repeat (400) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
